icache_controller: RTL and testbench
====================================

# icache_controller

Direct-mapped instruction cache sitting between the PC register and instruction memory in the single-cycle processor. It takes the current PC, returns the 32-bit instruction on a hit in the same cycle, and on a miss stalls the core via `busywait` while it fetches a 16-byte block from instruction memory over a multi-cycle handshake. Its `busywait` is the signal the PC adder samples to hold the next-PC update.

## Interface
- `BLOCKS`, 8: number of cache lines (index width = log2(BLOCKS) = 3).
- `CLK`  in  1  system clock, rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `PC`  in  32  fetch address; bits [9:0] used; word aligned.
- `INSTRUCTION`  out  32  fetched instruction.
- `busywait`  out  1  stall request to PC adder / core.
- `mem_read`  out  1  block read request to instruction memory.
- `mem_address`  out  6  block address = PC[9:4].
- `mem_readdata`  in  128  block data, word k in bits [32k+31:32k].
- `mem_busywait`  in  1  memory busy; data valid on the edge it is sampled low.

## Operation
- Address split: tag = PC[9:7], index = PC[6:4], word offset = PC[3:2]; PC[1:0] ignored.
- Per line storage: valid bit, 3-bit tag, 128-bit data.
- hit = valid[index] && tag[index] == PC[9:7]; combinational.
- INSTRUCTION = data[index] word selected by offset; combinational, valid only while hit.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE: hit -> stay, busywait 0. Miss -> busywait 1 combinationally; next edge -> MEM_READ.
  - MEM_READ: mem_read 1, mem_address = PC[9:4], busywait 1. Stay while mem_busywait 1; on edge with mem_busywait 0 capture mem_readdata, go UPDATE.
  - UPDATE: mem_read 0, busywait 1; write data, tag, set valid for index; next edge -> IDLE (now hit).
- Replacement: direct-mapped overwrite; no dirty state (read-only cache).
- PC must be held stable by upstream while busywait is 1; behaviour otherwise undefined.

## Timing
- Reset values (while RESET high, asynchronously): state IDLE, all valid 0, tags 0, busywait 0, mem_read 0, mem_address 0, INSTRUCTION 32'h0.
- Hit latency: 0 cycles (combinational from PC).
- Miss penalty: 1 (IDLE->MEM_READ) + N memory cycles + 1 (UPDATE) edges; instruction valid and busywait 0 in the cycle after UPDATE.
- mem_read asserted from the first MEM_READ cycle until the edge on which mem_busywait is sampled low; deasserted in UPDATE.
- Reset mid-miss: FSM returns to IDLE, mem_read drops immediately, partial fill discarded, all lines invalid.
- Index wrap: PC 0x3FC maps to index 7, offset 3; PC above 0x3FF aliases on bits [9:0].

## Configuration
- `ICACHE_STATS_EN` defined: adds outputs `hit_count` (out 16) and `miss_count` (out 16), reset to 0, saturating at 16'hFFFF.
  - miss_count +1 on each IDLE->MEM_READ transition.
  - hit_count +1 on each IDLE edge with hit where PC differs from PC sampled at the previous edge, or on the first IDLE hit edge after a fill or reset.
- Not defined: ports and counters absent; functional behaviour identical.

## Test plan
- Reset, PC=0x000, memory busy 5 cycles returning block {w3,w2,w1,w0}={0x33,0x22,0x11,0x00}: busywait 1, mem_read 1, mem_address 6'd0 until fill; after UPDATE busywait 0, INSTRUCTION=0x00.
- After fill, PC=0x004, 0x008, 0x00C: INSTRUCTION 0x11, 0x22, 0x33, busywait 0, mem_read never asserted.
- Conflict: PC=0x080 -> miss, mem_address 6'd8, line 0 replaced; return to PC=0x000 -> miss again, mem_address 6'd0.
- Assert RESET during MEM_READ: mem_read and busywait 0 same timestep; after release PC=0x000 misses again.
- PC=0x3FC cold: mem_address 6'd63, index 7 filled, INSTRUCTION = word 3 of returned block.
- With `ICACHE_STATS_EN`: sequence of scenarios 1-2 -> miss_count=1, hit_count=4 (PC 0x000 first hit after fill, then 0x004, 0x008, 0x00C).

Source files
------------

// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache: 8 lines x 16-byte blocks, hit in the same cycle.
// Optional ICACHE_STATS_EN macro adds saturating hit_count / miss_count outputs.
module icache_controller #(
   parameter int BLOCKS = 8
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [31:0]  PC,
   output logic [31:0]  INSTRUCTION,
   output logic         busywait,
   output logic         mem_read,
   output logic [5:0]   mem_address,
   input  logic [127:0] mem_readdata,
   input  logic         mem_busywait
`ifdef ICACHE_STATS_EN
   ,
   output logic [15:0]  hit_count,
   output logic [15:0]  miss_count
`endif
);

   localparam int IDX_W = $clog2(BLOCKS);
   localparam int TAG_W = 6 - IDX_W;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_READ = 2'd1,
      UPDATE   = 2'd2
   } state_t;

   state_t             state_r;
   state_t             next_state_s;
   logic [BLOCKS-1:0]  valid_r;
   logic [TAG_W-1:0]   tag_r  [BLOCKS];
   logic [127:0]       data_r [BLOCKS];
   logic [127:0]       fill_r;

   logic [IDX_W-1:0]   idx_s;
   logic [TAG_W-1:0]   tag_s;
   logic [1:0]         offset_s;
   logic               hit_s;
   logic               busywait_s;
   logic               mem_read_s;
   logic [5:0]         mem_address_s;
   logic               unused_pc_s;

   function automatic logic [31:0] select_word(input logic [127:0] blk, input logic [1:0] off);
      logic [31:0] w;
      case (off)
         2'd0:    w = blk[31:0];
         2'd1:    w = blk[63:32];
         2'd2:    w = blk[95:64];
         2'd3:    w = blk[127:96];
         default: w = blk[31:0];
      endcase
      return w;
   endfunction

   assign idx_s       = PC[4+IDX_W-1:4];
   assign tag_s       = PC[9:4+IDX_W];
   assign offset_s    = PC[3:2];
   assign unused_pc_s = ^{PC[31:10], PC[1:0]};

   assign hit_s       = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
   assign INSTRUCTION = hit_s ? select_word(data_r[idx_s], offset_s) : 32'h0000_0000;

   // A miss raises busywait before the state register moves, so it is masked by RESET directly.
   assign busywait    = busywait_s & ~RESET;
   assign mem_read    = mem_read_s;
   assign mem_address = mem_address_s;

   // Next-state and handshake outputs.
   always_comb begin
      next_state_s  = state_r;
      busywait_s    = 1'b0;
      mem_read_s    = 1'b0;
      mem_address_s = 6'd0;
      case (state_r)
         IDLE: begin
            if (!hit_s) begin
               busywait_s   = 1'b1;
               next_state_s = MEM_READ;
            end else begin
               next_state_s = IDLE;
            end
         end
         MEM_READ: begin
            busywait_s    = 1'b1;
            mem_read_s    = 1'b1;
            mem_address_s = PC[9:4];
            if (!mem_busywait) begin
               next_state_s = UPDATE;
            end else begin
               next_state_s = MEM_READ;
            end
         end
         UPDATE: begin
            busywait_s   = 1'b1;
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State register, fill buffer and line storage.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r <= IDLE;
         fill_r  <= 128'd0;
         valid_r <= {BLOCKS{1'b0}};
         for (int i = 0; i < BLOCKS; i++) begin
            tag_r[i]  <= {TAG_W{1'b0}};
            data_r[i] <= 128'd0;
         end
      end else begin
         state_r <= next_state_s;
         if (state_r == MEM_READ && !mem_busywait) begin
            fill_r <= mem_readdata;
         end
         if (state_r == UPDATE) begin
            data_r[idx_s]  <= fill_r;
            tag_r[idx_s]   <= tag_s;
            valid_r[idx_s] <= 1'b1;
         end
      end
   end

`ifdef ICACHE_STATS_EN
   logic [15:0] hit_count_r;
   logic [15:0] miss_count_r;
   logic [7:0]  prev_pc_r;
   logic        first_hit_r;

   assign hit_count  = hit_count_r;
   assign miss_count = miss_count_r;

   // A held PC counts as one hit; the first hit after a fill or reset always counts.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         hit_count_r  <= 16'd0;
         miss_count_r <= 16'd0;
         prev_pc_r    <= 8'd0;
         first_hit_r  <= 1'b1;
      end else begin
         prev_pc_r <= PC[9:2];
         if (state_r == UPDATE) begin
            first_hit_r <= 1'b1;
         end else if (state_r == IDLE && hit_s) begin
            first_hit_r <= 1'b0;
         end
         if (state_r == IDLE && hit_s && (first_hit_r || PC[9:2] != prev_pc_r)
             && hit_count_r != 16'hFFFF) begin
            hit_count_r <= hit_count_r + 16'd1;
         end
         if (state_r == IDLE && !hit_s && miss_count_r != 16'hFFFF) begin
            miss_count_r <= miss_count_r + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Bench for icache_controller: directed table, reset-mid-miss sequence and random fetches
// checked against a line-level cache model and a ROM whose word content encodes its address.
module tb_icache_controller;

   logic         CLK;
   logic         RESET;
   logic [31:0]  PC;
   logic [31:0]  INSTRUCTION;
   logic         busywait;
   logic         mem_read;
   logic [5:0]   mem_address;
   logic [127:0] mem_readdata;
   logic         mem_busywait;
`ifdef ICACHE_STATS_EN
   logic [15:0]  hit_count;
   logic [15:0]  miss_count;
`endif

   int vectors = 0;
   int miscompares = 0;
   int mem_lat = 0;

   bit         mvalid [8];
   logic [2:0] mtag   [8];

   icache_controller dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .PC           (PC),
      .INSTRUCTION  (INSTRUCTION),
      .busywait     (busywait),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count    (hit_count),
      .miss_count   (miss_count)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Word k of block b: block number in bits [29:24], k*0x11 in the low byte.
   function automatic logic [31:0] word_of(input logic [5:0] b, input logic [1:0] k);
      return {2'b00, b, 16'h0000, 2'b00, k, 2'b00, k};
   endfunction

   function automatic logic [127:0] block_of(input logic [5:0] b);
      return {word_of(b, 2'd3), word_of(b, 2'd2), word_of(b, 2'd1), word_of(b, 2'd0)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Instruction memory: busy for mem_lat negedges after seeing mem_read, then data with busy low.
   initial begin
      int cnt;
      cnt = 0;
      mem_busywait = 1'b0;
      mem_readdata = 128'd0;
      forever begin
         @(negedge CLK);
         if (mem_read) begin
            if (cnt < mem_lat) begin
               mem_busywait = 1'b1;
               cnt++;
            end else begin
               mem_busywait = 1'b0;
               mem_readdata = block_of(mem_address);
            end
         end else begin
            cnt = 0;
            mem_busywait = 1'b0;
            mem_readdata = {4{32'hDEAD_BEEF}};
         end
      end
   end

   // Called just after a negedge; returns at the next negedge after the fetch completes.
   task automatic fetch(input logic [31:0] pc, input int lat, input bit exp_hit,
                        input logic [31:0] exp_instr, input logic [5:0] exp_addr, input string name);
      int edges;
      bit rd_seen;
      logic [5:0] bad_addr;
      bit addr_bad;
      PC = pc;
      mem_lat = lat;
      #1;
      check({name, " busywait"}, {31'd0, busywait}, {31'd0, !exp_hit});
      if (exp_hit) begin
         check({name, " instr"}, INSTRUCTION, exp_instr);
         check({name, " mem_read idle"}, {31'd0, mem_read}, 32'd0);
         @(negedge CLK);
      end else begin
         edges = 0;
         rd_seen = 1'b0;
         addr_bad = 1'b0;
         bad_addr = 6'd0;
         while (busywait && edges < 100) begin
            @(posedge CLK);
            edges++;
            @(negedge CLK);
            #1;
            if (mem_read) begin
               rd_seen = 1'b1;
               if (mem_address !== exp_addr) begin
                  addr_bad = 1'b1;
                  bad_addr = mem_address;
               end
            end
         end
         check({name, " penalty"}, edges, lat + 3);
         check({name, " mem_read seen"}, {31'd0, rd_seen}, 32'd1);
         check({name, " mem_address"}, {26'd0, addr_bad ? bad_addr : exp_addr}, {26'd0, exp_addr});
         check({name, " instr after fill"}, INSTRUCTION, exp_instr);
         check({name, " mem_read after fill"}, {31'd0, mem_read}, 32'd0);
         mvalid[pc[6:4]] = 1'b1;
         mtag[pc[6:4]] = pc[9:7];
         @(negedge CLK);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      int          lat;
      bit          hit;
      logic [31:0] instr;
      logic [5:0]  addr;
   } vec_t;

   vec_t tbl [10];

   initial begin
      tbl[0] = '{32'h0000_0000, 5, 1'b0, 32'h0000_0000, 6'd0};
      tbl[1] = '{32'h0000_0004, 0, 1'b1, 32'h0000_0011, 6'd0};
      tbl[2] = '{32'h0000_0008, 0, 1'b1, 32'h0000_0022, 6'd0};
      tbl[3] = '{32'h0000_000C, 0, 1'b1, 32'h0000_0033, 6'd0};
      tbl[4] = '{32'h0000_0080, 3, 1'b0, 32'h0800_0000, 6'd8};
      tbl[5] = '{32'h0000_0000, 1, 1'b0, 32'h0000_0000, 6'd0};
      tbl[6] = '{32'h0000_03FC, 2, 1'b0, 32'h3F00_0033, 6'd63};
      tbl[7] = '{32'h0000_03F0, 0, 1'b1, 32'h3F00_0000, 6'd63};
      tbl[8] = '{32'h0000_07FC, 0, 1'b1, 32'h3F00_0033, 6'd63};
      tbl[9] = '{32'h0000_0084, 0, 1'b0, 32'h0800_0011, 6'd8};

      for (int i = 0; i < 8; i++) begin
         mvalid[i] = 1'b0;
         mtag[i] = 3'd0;
      end

      RESET = 1'b1;
      PC = 32'h0000_0000;
      #1;
      check("reset busywait", {31'd0, busywait}, 32'd0);
      check("reset mem_read", {31'd0, mem_read}, 32'd0);
      check("reset mem_address", {26'd0, mem_address}, 32'd0);
      check("reset instr", INSTRUCTION, 32'h0000_0000);
`ifdef ICACHE_STATS_EN
      check("reset hit_count", {16'd0, hit_count}, 32'd0);
      check("reset miss_count", {16'd0, miss_count}, 32'd0);
`endif
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;

      for (int i = 0; i < 10; i++) begin
         fetch(tbl[i].pc, tbl[i].lat, tbl[i].hit, tbl[i].instr, tbl[i].addr, $sformatf("vec%0d", i));
`ifdef ICACHE_STATS_EN
         if (i == 3) begin
            check("stats hit_count", {16'd0, hit_count}, 32'd4);
            check("stats miss_count", {16'd0, miss_count}, 32'd1);
         end
`endif
      end

      // Reset in the middle of a fill: outputs drop at once, all lines invalidated.
      PC = 32'h0000_0100;
      mem_lat = 10;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      #1;
      check("midmiss mem_read before reset", {31'd0, mem_read}, 32'd1);
      RESET = 1'b1;
      #1;
      check("midmiss mem_read in reset", {31'd0, mem_read}, 32'd0);
      check("midmiss busywait in reset", {31'd0, busywait}, 32'd0);
      check("midmiss mem_address in reset", {26'd0, mem_address}, 32'd0);
      check("midmiss instr in reset", INSTRUCTION, 32'h0000_0000);
      @(negedge CLK);
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
      fetch(32'h0000_0000, 1, 1'b0, 32'h0000_0000, 6'd0, "post-reset miss");
      fetch(32'h0000_0004, 0, 1'b1, 32'h0000_0011, 6'd0, "post-reset hit");

      // Random fetches over two tags and both alias halves, checked against the line model.
      for (int n = 0; n < 80; n++) begin
         logic [31:0] pc;
         bit h;
         pc = {21'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 3'd5 : 3'd0,
               3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
         h = mvalid[pc[6:4]] && (mtag[pc[6:4]] == pc[9:7]);
         fetch(pc, int'($urandom_range(0, 4)), h, word_of(pc[9:4], pc[3:2]), pc[9:4],
               $sformatf("rand%0d pc=%h", n, pc));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
